v_hier_lane_scan: RTL and testbench
===================================

# v_hier_lane_scan

Parametrised successor to the fixed 4-lane hierarchy sub-block: captures a LANES×WIDTH input vector into a registered snapshot, then serialises it lane by lane over a valid/ready stream. Optionally ties lane 0 to a constant-ones source. Sits between the per-lane leaf cells and a downstream consumer that accepts one lane per transfer, in single-scan or continuous mode.

## Interface
- LANES, 4, number of lanes; legal 2..16
- WIDTH, 1, bits per lane; legal 1..32
- FORCE_LANE0, 1, 1 = lane 0 captures all-ones regardless of avec; 0 = lane 0 captures avec like the other lanes
- LW (localparam), max(1, $clog2(LANES)), lane index width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a scan; sampled only in IDLE
- mode  in  1  0 = single scan; 1 = continuous (re-capture at each wrap)
- avec  in  LANES*WIDTH  lane inputs; lane i = avec[i*WIDTH +: WIDTH]
- qvec  out  LANES*WIDTH  registered snapshot of last capture
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_lane  out  LW  lane index of current beat
- out_data  out  WIDTH  qvec slice for out_lane
- out_last  out  1  high when out_lane == LANES-1 and out_valid
- busy  out  1  high in SEND

## Operation
- States: IDLE, SEND.
- Reset (async, rst_n low): state IDLE; qvec = 0; idx = 0; out_valid, out_last, busy = 0; out_lane = 0; out_data = 0. Deassertion is synchronous to clk.
- IDLE, start = 1 at edge: capture avec into qvec (lane 0 forced to all-ones if FORCE_LANE0); idx = 0; go SEND.
- IDLE, start = 0: hold; qvec retains last snapshot.
- SEND: out_valid = 1, out_lane = idx, out_data = qvec[idx*WIDTH +: WIDTH], busy = 1.
- Transfer = out_valid & out_ready at edge.
- Transfer with idx < LANES-1: idx + 1.
- Transfer with idx == LANES-1 (wrap):
  - If live mode = 1: re-capture avec into qvec, idx = 0, stay in SEND.
  - If mode = 0: go IDLE, idx = 0.
- No transfer: idx, qvec and out_* hold. out_data must not change while out_valid & !out_ready, even if avec changes.
- start is ignored in SEND. mode is sampled only at wrap; changing it mid-scan has no effect until wrap.
- Reset asserted mid-scan: immediate return to reset values. The partial scan is discarded.

## Timing
- Start-to-first-beat latency: 1 cycle. start high at edge k gives qvec updated and out_valid = 1 after edge k.
- Throughput: 1 lane/cycle with out_ready held high. A single scan takes LANES cycles of out_valid.
- In continuous mode with out_ready held high, there is no bubble at wrap. Lane 0 of the new snapshot follows lane LANES-1 on the next cycle.
- After a mode = 0 wrap, out_valid = 0 from the next cycle. start in that same IDLE cycle launches a new scan one cycle later, so the minimum gap is 1 idle cycle.
- out_valid, out_lane, out_data and out_last are registered or derived only from registered state. There is no combinational path from out_ready or avec to any output.

## Test plan
- Reset values: assert rst_n = 0 mid-SEND with LANES = 4, WIDTH = 4 -> all outputs 0 asynchronously, before the next clk edge; state IDLE after release.
- Single scan: LANES = 4, WIDTH = 4, FORCE_LANE0 = 1, avec = 16'hA5C3, mode = 0, out_ready = 1, pulse start.
  - Beats (lane, data): (0, F), (1, C), (2, 5), (3, A); out_last on the 4th beat only.
  - out_valid low on the next cycle; qvec = 16'hA5CF.
- Backpressure: same setup, out_ready = 0 for 3 cycles on lane 2 while avec toggles -> out_lane = 2 and out_data = 5 held stable; scan completes after ready returns.
- Continuous: mode = 1, avec changes from 16'h1234 to 16'h5678 mid-scan.
  - First scan emits 4,3,2,1 (lane 0 forced to F if FORCE_LANE0).
  - Second scan emits 8,7,6,5 with no bubble.
  - Drop mode before the second wrap -> IDLE after lane 3.
- FORCE_LANE0 = 0, LANES = 2, WIDTH = 1, avec = 2'b10 -> beats (0, 0), (1, 1); out_lane width 1.
- start during SEND is ignored: pulse start at lane 1 -> no restart, idx continues 2, 3; exactly 4 beats.

Source files
------------

// File: rtl/v_hier_lane_scan.sv
// Captures a LANES x WIDTH input vector into a snapshot and streams it out one lane per
// valid/ready beat, either as a single scan or continuously with a re-capture at each wrap.
module v_hier_lane_scan #(
    parameter int LANES       = 4,
    parameter int WIDTH       = 1,
    parameter bit FORCE_LANE0 = 1'b1,
    localparam int LW         = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   mode,
    input  logic [LANES*WIDTH-1:0] avec,
    output logic [LANES*WIDTH-1:0] qvec,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LW-1:0]          out_lane,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last,
    output logic                   busy
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam logic [LW-1:0] LAST_IDX = LW'(LANES - 1);

    state_t                   state_q, state_d;
    logic [LW-1:0]            idx_q, idx_d;
    logic [LANES*WIDTH-1:0]   qvec_q, qvec_d;
    logic [LANES*WIDTH-1:0]   captured;

    always_comb begin
        captured = avec;
        if (FORCE_LANE0) begin
            captured[WIDTH-1:0] = '1;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        qvec_d  = qvec_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    qvec_d  = captured;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        // mode is only consulted here, so mid-scan changes take effect at the wrap
                        if (mode) begin
                            qvec_d = captured;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            qvec_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            qvec_q  <= qvec_d;
        end
    end

    // All stream outputs decode registered state only; nothing flows through from out_ready or avec.
    always_comb begin
        qvec      = qvec_q;
        out_valid = (state_q == SEND);
        busy      = (state_q == SEND);
        out_lane  = '0;
        out_data  = '0;
        out_last  = 1'b0;
        if (state_q == SEND) begin
            out_lane = idx_q;
            out_data = qvec_q[int'(idx_q)*WIDTH +: WIDTH];
            out_last = (idx_q == LAST_IDX);
        end
    end

endmodule

// File: tb/tb_v_hier_lane_scan.sv
// Directed bench for v_hier_lane_scan: forced/unforced 4x4 instances plus a 2x1 instance,
// covering reset, single scan, backpressure, continuous mode and ignored start.
module tb_v_hier_lane_scan;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [15:0] avec;
    logic        out_ready;

    logic [15:0] qvec_a, qvec_c;
    logic        out_valid_a, out_last_a, busy_a;
    logic        out_valid_c, out_last_c, busy_c;
    logic [1:0]  out_lane_a, out_lane_c;
    logic [3:0]  out_data_a, out_data_c;

    logic        start_b;
    logic [1:0]  avec_b;
    logic [1:0]  qvec_b;
    logic        out_valid_b, out_last_b, busy_b;
    logic        out_lane_b;
    logic        out_data_b;

    int n_cmp;
    int n_fail;

    v_hier_lane_scan #(.LANES(4), .WIDTH(4), .FORCE_LANE0(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .avec(avec), .qvec(qvec_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_lane(out_lane_a),
        .out_data(out_data_a), .out_last(out_last_a), .busy(busy_a)
    );

    v_hier_lane_scan #(.LANES(4), .WIDTH(4), .FORCE_LANE0(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .avec(avec), .qvec(qvec_c),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_lane(out_lane_c),
        .out_data(out_data_c), .out_last(out_last_c), .busy(busy_c)
    );

    v_hier_lane_scan #(.LANES(2), .WIDTH(1), .FORCE_LANE0(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mode(1'b0), .avec(avec_b), .qvec(qvec_b),
        .out_valid(out_valid_b), .out_ready(1'b1), .out_lane(out_lane_b),
        .out_data(out_data_b), .out_last(out_last_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks one beat on the forced 4x4 instance, then moves to the next sampling point.
    task automatic beat_a(input string tag, input int lane, input int data, input bit last);
        check_output({tag, ".valid"}, 32'(out_valid_a), 32'd1);
        check_output({tag, ".lane"},  32'(out_lane_a),  32'(lane));
        check_output({tag, ".data"},  32'(out_data_a),  32'(data));
        check_output({tag, ".last"},  32'(out_last_a),  32'(last));
        @(negedge clk);
    endtask

    task automatic beat_c(input string tag, input int lane, input int data, input bit last);
        check_output({tag, ".valid"}, 32'(out_valid_c), 32'd1);
        check_output({tag, ".lane"},  32'(out_lane_c),  32'(lane));
        check_output({tag, ".data"},  32'(out_data_c),  32'(data));
        check_output({tag, ".last"},  32'(out_last_c),  32'(last));
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [15:0] v, input logic m);
        avec  = v;
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        mode      = 1'b0;
        avec      = '0;
        out_ready = 1'b1;
        start_b   = 1'b0;
        avec_b    = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check_output("rst.valid", 32'(out_valid_a), 32'd0);
        check_output("rst.busy",  32'(busy_a),      32'd0);
        check_output("rst.qvec",  32'(qvec_a),      32'd0);
        check_output("rst.lane",  32'(out_lane_a),  32'd0);
        check_output("rst.data",  32'(out_data_a),  32'd0);

        $display("[TB] single scan");
        apply_stimulus(16'hA5C3, 1'b0);
        beat_a("single.b0", 0, 4'hF, 1'b0);
        beat_a("single.b1", 1, 4'hC, 1'b0);
        beat_a("single.b2", 2, 4'h5, 1'b0);
        beat_a("single.b3", 3, 4'hA, 1'b1);
        check_output("single.idle_valid", 32'(out_valid_a), 32'd0);
        check_output("single.idle_busy",  32'(busy_a),      32'd0);
        check_output("single.qvec",       32'(qvec_a),      32'hA5CF);

        $display("[TB] backpressure");
        apply_stimulus(16'hA5C3, 1'b0);
        beat_a("bp.b0", 0, 4'hF, 1'b0);
        beat_a("bp.b1", 1, 4'hC, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_output("bp.hold_valid", 32'(out_valid_a), 32'd1);
            check_output("bp.hold_lane",  32'(out_lane_a),  32'd2);
            check_output("bp.hold_data",  32'(out_data_a),  32'h5);
            avec = avec ^ 16'hFFFF;
            @(negedge clk);
        end
        check_output("bp.qvec", 32'(qvec_a), 32'hA5CF);
        out_ready = 1'b1;
        beat_a("bp.b2", 2, 4'h5, 1'b0);
        beat_a("bp.b3", 3, 4'hA, 1'b1);
        check_output("bp.idle_valid", 32'(out_valid_a), 32'd0);

        $display("[TB] start ignored during SEND");
        apply_stimulus(16'h1357, 1'b0);
        beat_a("ign.b0", 0, 4'hF, 1'b0);
        start = 1'b1;
        avec  = 16'h0000;
        beat_a("ign.b1", 1, 4'h5, 1'b0);
        start = 1'b0;
        beat_a("ign.b2", 2, 4'h3, 1'b0);
        beat_a("ign.b3", 3, 4'h1, 1'b1);
        check_output("ign.idle_valid", 32'(out_valid_a), 32'd0);

        $display("[TB] continuous");
        apply_stimulus(16'h1234, 1'b1);
        check_output("cont.forced_lane0", 32'(out_data_a), 32'hF);
        beat_c("cont.s1b0", 0, 4'h4, 1'b0);
        beat_c("cont.s1b1", 1, 4'h3, 1'b0);
        avec = 16'h5678;
        beat_c("cont.s1b2", 2, 4'h2, 1'b0);
        beat_c("cont.s1b3", 3, 4'h1, 1'b1);
        check_output("cont.s2_forced_lane0", 32'(out_data_a), 32'hF);
        beat_c("cont.s2b0", 0, 4'h8, 1'b0);
        beat_c("cont.s2b1", 1, 4'h7, 1'b0);
        mode = 1'b0;
        beat_c("cont.s2b2", 2, 4'h6, 1'b0);
        beat_c("cont.s2b3", 3, 4'h5, 1'b1);
        check_output("cont.idle_valid", 32'(out_valid_c), 32'd0);
        check_output("cont.qvec",       32'(qvec_c),      32'h5678);

        // Restart in the first idle cycle: one-cycle minimum gap.
        apply_stimulus(16'h9ABC, 1'b0);
        beat_c("gap.b0", 0, 4'hC, 1'b0);
        beat_c("gap.b1", 1, 4'hB, 1'b0);
        beat_c("gap.b2", 2, 4'hA, 1'b0);
        beat_c("gap.b3", 3, 4'h9, 1'b1);
        check_output("gap.idle_valid", 32'(out_valid_c), 32'd0);

        $display("[TB] two-lane unforced");
        avec_b  = 2'b10;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check_output("b.b0_valid", 32'(out_valid_b), 32'd1);
        check_output("b.b0_lane",  32'(out_lane_b),  32'd0);
        check_output("b.b0_data",  32'(out_data_b),  32'd0);
        check_output("b.b0_last",  32'(out_last_b),  32'd0);
        @(negedge clk);
        check_output("b.b1_lane",  32'(out_lane_b),  32'd1);
        check_output("b.b1_data",  32'(out_data_b),  32'd1);
        check_output("b.b1_last",  32'(out_last_b),  32'd1);
        @(negedge clk);
        check_output("b.idle_valid", 32'(out_valid_b), 32'd0);
        check_output("b.qvec",       32'(qvec_b),      32'h2);

        $display("[TB] reset mid-scan");
        apply_stimulus(16'hA5C3, 1'b0);
        beat_a("mid.b0", 0, 4'hF, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_output("mid.valid", 32'(out_valid_a), 32'd0);
        check_output("mid.busy",  32'(busy_a),      32'd0);
        check_output("mid.last",  32'(out_last_a),  32'd0);
        check_output("mid.lane",  32'(out_lane_a),  32'd0);
        check_output("mid.data",  32'(out_data_a),  32'd0);
        check_output("mid.qvec",  32'(qvec_a),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("mid.post_valid", 32'(out_valid_a), 32'd0);
        check_output("mid.post_busy",  32'(busy_a),      32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
